// File: rtl/jtdd_rom_slot_pkg.sv
// Shared types and constants for the jtdd ROM slot: FSM states, line geometry
// and the byte-select helper used by the line storage.
package jtdd_rom_slot_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_FILL = 2'd2
  } state_e;

  localparam int LINE_BYTES = 4;
  localparam int WORD_W     = 16;
  localparam int LINE_W     = 8 * LINE_BYTES;

  // Byte 0 sits in the least significant bits, matching the even-address-low SDRAM layout.
  function automatic logic [7:0] pick_byte(input logic [LINE_W-1:0] line, input logic [1:0] sel);
    logic [7:0] b;
    case (sel)
      2'd0:    b = line[7:0];
      2'd1:    b = line[15:8];
      2'd2:    b = line[23:16];
      2'd3:    b = line[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/jtdd_rom_slot_if.sv
// Bundle of the client ROM request port and the SDRAM burst port seen by one ROM slot.
// slave = the slot itself, master = the client/back-end side driving it.
interface jtdd_rom_slot_if #(
  parameter int AW = 18
);
  logic          downloading;
  logic          rom_cs;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data;
  logic          rom_ok;
  logic          sdram_req;
  logic [AW-2:0] sdram_addr;
  logic          sdram_ack;
  logic          sdram_rdy;
  logic [15:0]   sdram_din;

  modport slave (
    input  downloading, rom_cs, rom_addr, sdram_ack, sdram_rdy, sdram_din,
    output rom_data, rom_ok, sdram_req, sdram_addr
  );

  modport master (
    output downloading, rom_cs, rom_addr, sdram_ack, sdram_rdy, sdram_din,
    input  rom_data, rom_ok, sdram_req, sdram_addr
  );
endinterface

// File: rtl/jtdd_rom_line.sv
// One cache line of the ROM slot: valid bit, tag and 4 data bytes, with a
// combinational lookup (hit + selected byte) and word-wise burst writes.
module jtdd_rom_line
  import jtdd_rom_slot_pkg::*;
#(
  parameter int TW = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              we,
  input  logic              wsel,
  input  logic [WORD_W-1:0] wdata,
  input  logic              commit,
  input  logic [TW-1:0]     commit_tag,
  input  logic [TW-1:0]     look_tag,
  input  logic [1:0]        look_byte,
  output logic              hit,
  output logic [7:0]        rd_byte
);

  logic              valid_q, valid_d;
  logic [TW-1:0]     tag_q, tag_d;
  logic [LINE_W-1:0] data_q, data_d;

  // A line being overwritten drops its valid bit until the burst commits.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (clr) begin
      valid_d = 1'b0;
    end else if (commit) begin
      valid_d = 1'b1;
    end else if (we) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
    if (commit) begin
      tag_d = commit_tag;
    end else begin
      tag_d = tag_q;
    end
    if (we) begin
      if (wsel) begin
        data_d[31:16] = wdata;
      end else begin
        data_d[15:0] = wdata;
      end
    end else begin
      data_d = data_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      tag_q   <= {TW{1'b0}};
      data_q  <= {LINE_W{1'b0}};
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  assign hit     = valid_q & (tag_q == look_tag);
  assign rd_byte = pick_byte(data_q, look_byte);

endmodule

// File: rtl/jtdd_rom_slot.sv
// ROM slot: serves client byte reads from a small line cache refilled by 2-word SDRAM bursts.
// Define JTDD_ROM_SLOT_2WAY_EN for two lines with a round-robin victim; otherwise one line.
module jtdd_rom_slot
  import jtdd_rom_slot_pkg::*;
#(
  parameter int AW = 18,
  parameter int LW = 2
) (
  input logic            clk,
  input logic            rst,
  jtdd_rom_slot_if.slave bus
);

  localparam int TW = AW - LW;
`ifdef JTDD_ROM_SLOT_2WAY_EN
  localparam int NL = 2;
`else
  localparam int NL = 1;
`endif

  state_e        state_q, state_d;
  logic          req_q, req_d;
  logic [AW-2:0] saddr_q, saddr_d;
  logic [TW-1:0] ftag_q, ftag_d;
  logic          cnt_q, cnt_d;
  logic          dl_seen_q, dl_seen_d;
  logic          ok_q, ok_d;
  logic [7:0]    data_q, data_d;
`ifdef JTDD_ROM_SLOT_2WAY_EN
  logic          ptr_q, ptr_d;
`endif

  logic [TW-1:0] look_tag_s;
  logic [NL-1:0] hit_s;
  logic [NL-1:0] we_s;
  logic [NL-1:0] commit_v_s;
  logic [7:0]    rd_byte_s [NL];
  logic          hit_any_s;
  logic [7:0]    hit_byte_s;
  logic          we_any_s;
  logic          wsel_s;
  logic          commit_s;

  assign look_tag_s = bus.rom_addr[AW-1:LW];

  for (genvar i = 0; i < NL; i++) begin : g_line
    jtdd_rom_line #(.TW(TW)) u_line (
      .clk        (clk),
      .rst        (rst),
      .clr        (bus.downloading),
      .we         (we_s[i]),
      .wsel       (wsel_s),
      .wdata      (bus.sdram_din),
      .commit     (commit_v_s[i]),
      .commit_tag (ftag_q),
      .look_tag   (look_tag_s),
      .look_byte  (bus.rom_addr[1:0]),
      .hit        (hit_s[i]),
      .rd_byte    (rd_byte_s[i])
    );
  end

`ifdef JTDD_ROM_SLOT_2WAY_EN
  assign we_s       = {we_any_s & ptr_q, we_any_s & ~ptr_q};
  assign commit_v_s = {commit_s & ptr_q, commit_s & ~ptr_q};
`else
  assign we_s       = we_any_s;
  assign commit_v_s = commit_s;
`endif

  // Merge the per-line lookups; at most one line can hold a given tag.
  always_comb begin
    hit_any_s  = |hit_s;
    hit_byte_s = 8'h00;
    for (int i = 0; i < NL; i++) begin
      if (hit_s[i]) begin
        hit_byte_s = rd_byte_s[i];
      end else begin
        hit_byte_s = hit_byte_s;
      end
    end
  end

  // Fetch FSM, burst word counter and registered client outputs.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    saddr_d   = saddr_q;
    ftag_d    = ftag_q;
    cnt_d     = cnt_q;
    dl_seen_d = dl_seen_q;
    we_any_s  = 1'b0;
    wsel_s    = 1'b0;
    commit_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.rom_cs & ~hit_any_s & ~bus.downloading) begin
          state_d   = ST_REQ;
          req_d     = 1'b1;
          ftag_d    = look_tag_s;
          saddr_d   = {look_tag_s, 1'b0};
          dl_seen_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        dl_seen_d = dl_seen_q | bus.downloading;
        if (bus.sdram_ack) begin
          req_d   = 1'b0;
          state_d = ST_FILL;
          cnt_d   = 1'b0;
          // The first word may arrive together with the ack.
          if (bus.sdram_rdy) begin
            we_any_s = 1'b1;
            wsel_s   = 1'b0;
            cnt_d    = 1'b1;
          end else begin
            cnt_d = 1'b0;
          end
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_FILL: begin
        dl_seen_d = dl_seen_q | bus.downloading;
        if (bus.sdram_rdy) begin
          we_any_s = 1'b1;
          wsel_s   = cnt_q;
          if (cnt_q) begin
            commit_s = ~dl_seen_q & ~bus.downloading;
            cnt_d    = 1'b0;
            state_d  = ST_IDLE;
          end else begin
            cnt_d = 1'b1;
          end
        end else begin
          state_d = ST_FILL;
        end
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
        cnt_d   = 1'b0;
      end
    endcase

    ok_d = bus.rom_cs & hit_any_s & ~bus.downloading;
    if (ok_d) begin
      data_d = hit_byte_s;
    end else begin
      data_d = data_q;
    end
  end

`ifdef JTDD_ROM_SLOT_2WAY_EN
  // Round-robin victim advances only when a fill actually becomes valid.
  always_comb begin
    if (commit_s) begin
      ptr_d = ~ptr_q;
    end else begin
      ptr_d = ptr_q;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      req_q     <= 1'b0;
      saddr_q   <= {(AW-1){1'b0}};
      ftag_q    <= {TW{1'b0}};
      cnt_q     <= 1'b0;
      dl_seen_q <= 1'b0;
      ok_q      <= 1'b0;
      data_q    <= 8'h00;
`ifdef JTDD_ROM_SLOT_2WAY_EN
      ptr_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      saddr_q   <= saddr_d;
      ftag_q    <= ftag_d;
      cnt_q     <= cnt_d;
      dl_seen_q <= dl_seen_d;
      ok_q      <= ok_d;
      data_q    <= data_d;
`ifdef JTDD_ROM_SLOT_2WAY_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  assign bus.rom_ok     = ok_q;
  assign bus.rom_data   = data_q;
  assign bus.sdram_req  = req_q;
  assign bus.sdram_addr = saddr_q;

endmodule

// File: tb/tb_jtdd_rom_slot.sv
// Self-checking bench for jtdd_rom_slot: directed scenarios plus random accesses
// checked against a tag-list cache model and a synthetic ROM content function.
module tb_jtdd_rom_slot;

  localparam int AW = 18;
`ifdef JTDD_ROM_SLOT_2WAY_EN
  localparam int NL = 2;
`else
  localparam int NL = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jtdd_rom_slot_if #(.AW(AW)) bus ();

  jtdd_rom_slot #(.AW(AW), .LW(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  bit m_valid [2];
  int m_tag   [2];
  int m_ptr;
  int pool    [6] = '{32'h1, 32'h40, 32'h41, 32'h2AAA, 32'hFFFF, 32'h0};

  function automatic logic [7:0] mem_byte(input int a);
    logic [31:0] v;
    case (a)
      4:       return 8'hAA;
      5:       return 8'hBB;
      6:       return 8'hCC;
      7:       return 8'hDD;
      default: begin
        v = a * 29 + (a >> 5);
        return v[7:0] ^ 8'h3C;
      end
    endcase
  endfunction

  function automatic logic [15:0] line_word(input int tag, input int w);
    return {mem_byte(tag * 4 + 2 * w + 1), mem_byte(tag * 4 + 2 * w)};
  endfunction

  function automatic bit model_hit(input int tag);
    for (int i = 0; i < NL; i++)
      if (m_valid[i] && m_tag[i] == tag) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_fill(input int tag);
`ifdef JTDD_ROM_SLOT_2WAY_EN
    m_valid[m_ptr] = 1'b1;
    m_tag[m_ptr]   = tag;
    m_ptr          = 1 - m_ptr;
`else
    m_valid[0] = 1'b1;
    m_tag[0]   = tag;
`endif
  endtask

  task automatic model_clear();
    m_valid[0] = 1'b0;
    m_valid[1] = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Back-end side of one burst; mode 2 moves the client address, mode 3 pulses downloading.
  task automatic serve(input int tag, input int ack_dly, input bit same, input int mode, input int new_addr);
    for (int d = 0; d < ack_dly; d++) begin
      bus.sdram_rdy = 1'($urandom_range(0, 1));
      bus.sdram_din = 16'($urandom);
      tick();
      bus.sdram_rdy = 1'b0;
      check("req_held", bus.sdram_req, 1);
      check("addr_held", bus.sdram_addr, tag * 2);
    end
    bus.sdram_ack = 1'b1;
    if (same) begin
      bus.sdram_rdy = 1'b1;
      bus.sdram_din = line_word(tag, 0);
    end
    tick();
    bus.sdram_ack = 1'b0;
    bus.sdram_rdy = 1'b0;
    check("req_drop", bus.sdram_req, 0);
    if (!same) begin
      repeat ($urandom_range(0, 2)) tick();
      bus.sdram_rdy = 1'b1;
      bus.sdram_din = line_word(tag, 0);
      tick();
      bus.sdram_rdy = 1'b0;
    end
    if (mode == 2) bus.rom_addr = 18'(new_addr);
    if (mode == 3) begin
      bus.downloading = 1'b1;
      tick();
      bus.downloading = 1'b0;
    end
    repeat ($urandom_range(0, 2)) tick();
    bus.sdram_rdy = 1'b1;
    bus.sdram_din = line_word(tag, 1);
    tick();
    bus.sdram_rdy = 1'b0;
    check("ok_at_fill", bus.rom_ok, 0);
  endtask

  task automatic access(input int a, input int ack_dly, input bit same, input int mode, input int a2);
    int tag;
    int ra;
    tag = a >> 2;
    ra  = a;
    bus.rom_addr = 18'(a);
    bus.rom_cs   = 1'b1;
    tick();
    if (model_hit(tag)) begin
      check("hit_ok", bus.rom_ok, 1);
      check("hit_data", bus.rom_data, mem_byte(a));
      check("hit_noreq", bus.sdram_req, 0);
    end else begin
      check("miss_ok", bus.rom_ok, 0);
      check("miss_req", bus.sdram_req, 1);
      check("miss_addr", bus.sdram_addr, tag * 2);
      serve(tag, ack_dly, same, mode, a2);
      if (mode == 3) begin
        model_clear();
        tick();
        check("rereq", bus.sdram_req, 1);
        check("rereq_addr", bus.sdram_addr, tag * 2);
        serve(tag, $urandom_range(0, 3), 1'b0, 0, 0);
        model_fill(tag);
      end else if (mode == 2) begin
        model_fill(tag);
        ra  = a2;
        tag = a2 >> 2;
        tick();
        check("req2", bus.sdram_req, 1);
        check("req2_addr", bus.sdram_addr, tag * 2);
        serve(tag, $urandom_range(0, 3), 1'b0, 0, 0);
        model_fill(tag);
      end else begin
        model_fill(tag);
      end
      tick();
      check("fill_ok", bus.rom_ok, 1);
      check("fill_data", bus.rom_data, mem_byte(ra));
      check("fill_noreq", bus.sdram_req, 0);
    end
  endtask

  initial begin
    bus.downloading = 1'b0;
    bus.rom_cs      = 1'b0;
    bus.rom_addr    = 18'h0;
    bus.sdram_ack   = 1'b0;
    bus.sdram_rdy   = 1'b0;
    bus.sdram_din   = 16'h0;
    model_clear();
    m_ptr = 0;
    tick();
    tick();
    check("rst_ok", bus.rom_ok, 0);
    check("rst_data", bus.rom_data, 0);
    check("rst_req", bus.sdram_req, 0);
    check("rst_saddr", bus.sdram_addr, 0);
    rst = 1'b0;
    tick();
    check("idle_req", bus.sdram_req, 0);

    // Cold miss with ack at +3, then a hit sweep over the filled line.
    access(32'h5, 2, 1'b0, 0, 0);
    for (int b = 4; b < 8; b++) access(b, 0, 1'b0, 0, 0);

    // Downloading over a hit: no rom_ok, no fetch, and the line is gone afterwards.
    bus.downloading = 1'b1;
    tick();
    check("dl_ok", bus.rom_ok, 0);
    check("dl_noreq", bus.sdram_req, 0);
    tick();
    check("dl_noreq2", bus.sdram_req, 0);
    bus.downloading = 1'b0;
    model_clear();

    // Address change mid-fill, downloading pulsed mid-fill, ack with first rdy.
    access(32'h5, 1, 1'b0, 2, 32'h100);
    access(32'h22, 2, 1'b0, 3, 0);
    access(32'h31, 1, 1'b1, 0, 0);
    access(32'h33, 0, 1'b0, 0, 0);

    // Two-line replacement pattern (all misses in the single-line build).
    access(32'h401, 1, 1'b0, 0, 0);
    access(32'h802, 1, 1'b0, 0, 0);
    access(32'h403, 0, 1'b0, 0, 0);
    access(32'hC00, 1, 1'b0, 0, 0);
    access(32'h801, 0, 1'b0, 0, 0);
    access(32'h400, 1, 1'b0, 0, 0);

    // Async reset while a request is pending.
    bus.rom_addr = 18'h1234;
    bus.rom_cs   = 1'b1;
    tick();
    check("pre_rst_req", bus.sdram_req, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_req", bus.sdram_req, 0);
    check("arst_saddr", bus.sdram_addr, 0);
    bus.rom_cs = 1'b0;
    #2 rst = 1'b0;
    model_clear();
    m_ptr = 0;
    tick();
    access(32'h400, 1, 1'b0, 0, 0);

    // Random accesses over a small tag pool, including the top of the address space.
    for (int n = 0; n < 60; n++) begin
      int t;
      t = pool[$urandom_range(0, 5)];
      if ($urandom_range(0, 4) == 0) begin
        bus.rom_cs = 1'b0;
        tick();
        check("nocs_ok", bus.rom_ok, 0);
        check("nocs_req", bus.sdram_req, 0);
      end
      access(t * 4 + $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
